vpu_cmd_sched: RTL and testbench
================================

# vpu_cmd_sched

Command scheduler between the CPU's VPU issue port and the VPU. It queues up to `DEPTH` complete VPU commands (op, code, object fields, V0–V7 and RO operands), so the CPU only stalls when the queue is full rather than whenever the VPU is busy. It issues one command at a time with a registered single-cycle start pulse and tracks each command through the VPU ready handshake. It also reports queue occupancy and a drained/idle indication that the CPU uses before halting.

## Interface
- `DEPTH`, 4: queue entries; power of two, 2–16.
- `ACK_TIMEOUT`, 4: cycles to wait for `VPU_rdy` to fall after a start; 1–15.

- `clk` input 1: system clock. One clock domain.
- `rst_n` input 1: reset, asynchronous and active-low.
- `cmd_valid` input 1: CPU presents a command this cycle.
- `cmd_op` input 4: VPU op.
- `cmd_code` input 4: VPU code.
- `cmd_obj_num` input 5: object number.
- `cmd_obj_type` input 2: object type.
- `cmd_obj_color` input 3: object color.
- `cmd_fill` input 1: fill flag.
- `cmd_V0`…`cmd_V7` input 16 each: vertex operands.
- `cmd_RO` input 16: RO operand.
- `flush` input 1: discard all queued, not-yet-issued commands.
- `cmd_rdy` output 1: queue not full; the CPU stalls when low.
- `sched_idle` output 1: queue empty, FSM in IDLE, and `VPU_rdy` high.
- `q_count` output $clog2(DEPTH)+1: current occupancy.
- `VPU_rdy` input 1: VPU idle/ready.
- `start_VPU` output 1: single-cycle issue strobe.
- `op_VPU` 4, `code_VPU` 4, `obj_num_VPU` 5, `obj_type_VPU` 2, `obj_color_VPU` 3, `fill_VPU` 1, `V0_VPU`…`V7_VPU` 16 each, `RO_VPU` 16: all outputs. Command fields, registered, held stable from the start cycle until the next issue.
- `timeout_err` output 1: sticky; set when a timeout fires, cleared only by reset.

## Operation
- **Queue.** A circular FIFO of 163-bit entries with read/write pointers and an occupancy counter.
  - Enqueue when `cmd_valid && cmd_rdy`.
  - `cmd_valid` while full is ignored; the CPU is responsible for holding it.
- **FSM states:** IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
  - **IDLE:** if the queue is non-empty and `VPU_rdy`=1, go to ISSUE.
  - **ISSUE** (one cycle):
    - Load the head entry into the output field registers and assert `start_VPU`.
    - Pop the head and clear the timeout counter.
    - Go to WAIT_ACK.
  - **WAIT_ACK:**
    - If `VPU_rdy`=0, go to WAIT_DONE.
    - Else increment the counter. When it reaches `ACK_TIMEOUT`, treat the command as complete (the VPU finished instantly or ignored it), set `timeout_err`, and go to IDLE.
  - **WAIT_DONE:** when `VPU_rdy`=1, go to IDLE.
- **Flush.**
  - Resets the pointers and count to 0 in the same cycle.
  - Does not abort a command already issued; the FSM completes its handshake.
  - Flush has priority over a same-cycle enqueue, which is dropped.
- **Simultaneous enqueue and pop** (ISSUE cycle): the count is unchanged, and `cmd_rdy` stays as it was.
- **Pointer wrap-around** is modulo `DEPTH`.
- **Reset (asynchronous, mid-operation included):**
  - FSM goes to IDLE; pointers and count are 0.
  - `start_VPU`=0 and `timeout_err`=0.
  - All field outputs are 0.
  - `cmd_rdy`=1, `q_count`=0.
  - `sched_idle` follows `VPU_rdy`.
- **Output decoding.** `cmd_rdy` = (count != `DEPTH`), decoded combinationally from registered count. `sched_idle` is combinational from state, count and `VPU_rdy`.

## Timing
- **Enqueue-to-start latency with an empty queue and idle VPU:** command accepted at edge N; FSM sees non-empty and moves to ISSUE at edge N+1; `start_VPU` and the fields are high/valid during cycle N+1→N+2. That is, two edges of latency.
- **Back-to-back issue:** the minimum spacing between starts is 4 cycles (ISSUE, WAIT_ACK, WAIT_DONE with `VPU_rdy` returning immediately, IDLE).
- **`start_VPU` width:** never high for two consecutive cycles.
- **Field stability:** fields change only on the ISSUE edge.
- **`cmd_rdy` after a full queue:** rises the cycle after the pop edge.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-WAIT_DONE with 3 entries queued → immediately `start_VPU`=0, `q_count`=0, `cmd_rdy`=1, all fields 0; after release, no start occurs.
- **Single command:** `VPU_rdy`=1; enqueue op=4'h3, obj_num=5'h11, V0=16'hBEEF at edge N → `start_VPU` is high exactly one cycle after edge N+1 with those fields. Model the VPU as dropping `VPU_rdy` for 10 cycles → the next start waits until `VPU_rdy` returns.
- **Full/wrap:** hold `VPU_rdy`=0 and enqueue 5 commands with `DEPTH`=4 → `cmd_rdy`=0 after the 4th and the 5th is dropped. Release the VPU model; enqueue 6 more over time → 10 starts in FIFO order, with payload V1 = sequence number 0..9.
- **Timeout:** VPU model never drops `VPU_rdy` → the start is followed by a return to IDLE after 4 WAIT_ACK cycles, `timeout_err`=1, and the next queued command still issues.
- **Flush:** 3 queued, 1 in flight; assert `flush` together with `cmd_valid` → `q_count`=0, the in-flight command completes, no further starts, and `sched_idle`=1 once `VPU_rdy`=1.
- **Simultaneous enqueue/pop:** with `q_count`=4, the ISSUE edge coincides with `cmd_valid` → enqueue rejected (full), `q_count`=3 afterwards. With `q_count`=2 → `q_count` stays 2.

Source files
------------

// File: rtl/vpu_cmd_sched_if.sv
// CPU issue port and VPU port of the command scheduler, bundled.
// The DUT connects through the slave modport; the CPU/VPU side uses master.
interface vpu_cmd_sched_if #(
  parameter int unsigned DEPTH = 4
) ();
  // CPU -> scheduler
  logic        cmd_valid;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_code;
  logic [4:0]  cmd_obj_num;
  logic [1:0]  cmd_obj_type;
  logic [2:0]  cmd_obj_color;
  logic        cmd_fill;
  logic [15:0] cmd_V0;
  logic [15:0] cmd_V1;
  logic [15:0] cmd_V2;
  logic [15:0] cmd_V3;
  logic [15:0] cmd_V4;
  logic [15:0] cmd_V5;
  logic [15:0] cmd_V6;
  logic [15:0] cmd_V7;
  logic [15:0] cmd_RO;
  logic        flush;
  // scheduler -> CPU
  logic        cmd_rdy;
  logic        sched_idle;
  logic [$clog2(DEPTH):0] q_count;
  logic        timeout_err;
  // VPU <-> scheduler
  logic        VPU_rdy;
  logic        start_VPU;
  logic [3:0]  op_VPU;
  logic [3:0]  code_VPU;
  logic [4:0]  obj_num_VPU;
  logic [1:0]  obj_type_VPU;
  logic [2:0]  obj_color_VPU;
  logic        fill_VPU;
  logic [15:0] V0_VPU;
  logic [15:0] V1_VPU;
  logic [15:0] V2_VPU;
  logic [15:0] V3_VPU;
  logic [15:0] V4_VPU;
  logic [15:0] V5_VPU;
  logic [15:0] V6_VPU;
  logic [15:0] V7_VPU;
  logic [15:0] RO_VPU;

  modport slave (
    input  cmd_valid, cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color,
           cmd_fill, cmd_V0, cmd_V1, cmd_V2, cmd_V3, cmd_V4, cmd_V5, cmd_V6, cmd_V7,
           cmd_RO, flush, VPU_rdy,
    output cmd_rdy, sched_idle, q_count, timeout_err, start_VPU, op_VPU, code_VPU,
           obj_num_VPU, obj_type_VPU, obj_color_VPU, fill_VPU, V0_VPU, V1_VPU,
           V2_VPU, V3_VPU, V4_VPU, V5_VPU, V6_VPU, V7_VPU, RO_VPU
  );

  modport master (
    output cmd_valid, cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color,
           cmd_fill, cmd_V0, cmd_V1, cmd_V2, cmd_V3, cmd_V4, cmd_V5, cmd_V6, cmd_V7,
           cmd_RO, flush, VPU_rdy,
    input  cmd_rdy, sched_idle, q_count, timeout_err, start_VPU, op_VPU, code_VPU,
           obj_num_VPU, obj_type_VPU, obj_color_VPU, fill_VPU, V0_VPU, V1_VPU,
           V2_VPU, V3_VPU, V4_VPU, V5_VPU, V6_VPU, V7_VPU, RO_VPU
  );
endinterface

// File: rtl/vpu_cmd_sched.sv
// VPU command scheduler: DEPTH-entry command FIFO in front of the VPU, issuing
// one command at a time with a single-cycle start strobe and tracking the
// VPU_rdy fall/rise handshake (with an ack timeout).
// The interface instance must be built with the same DEPTH as this module.
module vpu_cmd_sched #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input logic            clk,
  input logic            rst_n,
  vpu_cmd_sched_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 163;
  localparam logic [AW:0] FULL     = (AW+1)'(DEPTH);
  localparam logic [3:0]  ACK_LAST = 4'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state, state_nx;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [3:0]    ack_cnt;
  logic          push, pop, ack_inc, timeout_hit;

  assign wr_entry = {bus.cmd_op, bus.cmd_code, bus.cmd_obj_num, bus.cmd_obj_type,
                     bus.cmd_obj_color, bus.cmd_fill, bus.cmd_V0, bus.cmd_V1,
                     bus.cmd_V2, bus.cmd_V3, bus.cmd_V4, bus.cmd_V5, bus.cmd_V6,
                     bus.cmd_V7, bus.cmd_RO};
  assign head     = mem[rd_ptr];

  assign bus.cmd_rdy    = (count != FULL);
  assign bus.q_count    = count;
  assign bus.sched_idle = (count == '0) && (state == IDLE) && bus.VPU_rdy;

  // Flush wins over a same-cycle enqueue.
  assign push = bus.cmd_valid && bus.cmd_rdy && !bus.flush;

  // Next-state and control decode.
  // The pop/field load happens on the IDLE->ISSUE edge so that start_VPU and
  // the fields are both valid during the ISSUE cycle; a flush on that edge
  // suppresses the issue, since the head is being discarded.
  always_comb begin
    state_nx    = state;
    pop         = 1'b0;
    ack_inc     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && bus.VPU_rdy && !bus.flush) begin
          state_nx = ISSUE;
          pop      = 1'b1;
        end
      end
      ISSUE: state_nx = WAIT_ACK;
      WAIT_ACK: begin
        if (!bus.VPU_rdy) begin
          state_nx = WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          state_nx    = IDLE;
          timeout_hit = 1'b1;
        end else begin
          ack_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.VPU_rdy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Queue pointers and occupancy; wrap is implicit in the AW-bit pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  // Ack timeout counter, cleared while the start strobe is out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ack_cnt <= '0;
    else if (state == ISSUE) ack_cnt <= '0;
    else if (ack_inc)        ack_cnt <= ack_cnt + 1'b1;
  end

  // Registered start strobe, held command fields and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.start_VPU   <= 1'b0;
      bus.timeout_err <= 1'b0;
      {bus.op_VPU, bus.code_VPU, bus.obj_num_VPU, bus.obj_type_VPU,
       bus.obj_color_VPU, bus.fill_VPU, bus.V0_VPU, bus.V1_VPU, bus.V2_VPU,
       bus.V3_VPU, bus.V4_VPU, bus.V5_VPU, bus.V6_VPU, bus.V7_VPU,
       bus.RO_VPU} <= '0;
    end else begin
      bus.start_VPU <= pop;
      if (timeout_hit) bus.timeout_err <= 1'b1;
      if (pop) begin
        {bus.op_VPU, bus.code_VPU, bus.obj_num_VPU, bus.obj_type_VPU,
         bus.obj_color_VPU, bus.fill_VPU, bus.V0_VPU, bus.V1_VPU, bus.V2_VPU,
         bus.V3_VPU, bus.V4_VPU, bus.V5_VPU, bus.V6_VPU, bus.V7_VPU,
         bus.RO_VPU} <= head;
      end
    end
  end
endmodule

// File: tb/tb_vpu_cmd_sched.sv
// Bench for vpu_cmd_sched: transaction-level model (queue of commands plus an
// in-flight handshake tracker) checked every cycle, plus directed literal checks.
module tb_vpu_cmd_sched;
  localparam int unsigned DEPTH       = 4;
  localparam int unsigned ACK_TIMEOUT = 4;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  code;
    logic [4:0]  obj_num;
    logic [1:0]  obj_type;
    logic [2:0]  obj_color;
    logic        fill;
    logic [15:0] v0, v1, v2, v3, v4, v5, v6, v7;
    logic [15:0] ro;
  } cmd_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vpu_cmd_sched_if #(.DEPTH(DEPTH)) bus ();

  vpu_cmd_sched #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_cmd(input string name, input cmd_t act, input cmd_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input int seq);
    cmd_t c;
    c.op        = 4'(seq);
    c.code      = 4'(seq + 7);
    c.obj_num   = 5'(seq * 3 + 1);
    c.obj_type  = 2'(seq);
    c.obj_color = 3'(seq + 2);
    c.fill      = 1'(seq);
    c.v0        = 16'(32'h1000 + seq);
    c.v1        = 16'(seq);
    c.v2        = 16'(seq * 257 + 2);
    c.v3        = 16'(seq * 257 + 3);
    c.v4        = 16'(seq * 257 + 4);
    c.v5        = 16'(seq * 257 + 5);
    c.v6        = 16'(seq * 257 + 6);
    c.v7        = 16'(seq * 257 + 7);
    c.ro        = 16'(32'hA000 ^ seq);
    return c;
  endfunction

  function automatic cmd_t dut_fields();
    cmd_t c;
    c.op = bus.op_VPU; c.code = bus.code_VPU; c.obj_num = bus.obj_num_VPU;
    c.obj_type = bus.obj_type_VPU; c.obj_color = bus.obj_color_VPU; c.fill = bus.fill_VPU;
    c.v0 = bus.V0_VPU; c.v1 = bus.V1_VPU; c.v2 = bus.V2_VPU; c.v3 = bus.V3_VPU;
    c.v4 = bus.V4_VPU; c.v5 = bus.V5_VPU; c.v6 = bus.V6_VPU; c.v7 = bus.V7_VPU;
    c.ro = bus.RO_VPU;
    return c;
  endfunction

  function automatic cmd_t bus_cmd();
    cmd_t c;
    c.op = bus.cmd_op; c.code = bus.cmd_code; c.obj_num = bus.cmd_obj_num;
    c.obj_type = bus.cmd_obj_type; c.obj_color = bus.cmd_obj_color; c.fill = bus.cmd_fill;
    c.v0 = bus.cmd_V0; c.v1 = bus.cmd_V1; c.v2 = bus.cmd_V2; c.v3 = bus.cmd_V3;
    c.v4 = bus.cmd_V4; c.v5 = bus.cmd_V5; c.v6 = bus.cmd_V6; c.v7 = bus.cmd_V7;
    c.ro = bus.cmd_RO;
    return c;
  endfunction

  task automatic drive(input cmd_t c, input logic v);
    bus.cmd_op = c.op; bus.cmd_code = c.code; bus.cmd_obj_num = c.obj_num;
    bus.cmd_obj_type = c.obj_type; bus.cmd_obj_color = c.obj_color; bus.cmd_fill = c.fill;
    bus.cmd_V0 = c.v0; bus.cmd_V1 = c.v1; bus.cmd_V2 = c.v2; bus.cmd_V3 = c.v3;
    bus.cmd_V4 = c.v4; bus.cmd_V5 = c.v5; bus.cmd_V6 = c.v6; bus.cmd_V7 = c.v7;
    bus.cmd_RO = c.ro;
    bus.cmd_valid = v;
  endtask

  // Inputs change 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input cmd_t c);
    drive(c, 1'b1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic enq_hold(input cmd_t c, input int budget);
    int k = 0;
    while (!bus.cmd_rdy && k < budget) begin
      tick();
      k++;
    end
    check_int("enq_wait_bound", int'(k < budget), 1);
    enq(c);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (!bus.sched_idle && k < budget) begin
      tick();
      k++;
    end
    check_int("idle_wait_bound", int'(k < budget), 1);
  endtask

  // VPU model: after seeing a start, drops VPU_rdy for busy_len cycles.
  bit vpu_hold    = 1'b0;
  bit vpu_respond = 1'b1;
  int busy_len    = 1;
  int vpu_busy    = 0;
  bit vpu_pend    = 1'b0;
  initial begin
    bus.VPU_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #3;
      if (!rst_n) begin
        vpu_busy = 0;
        vpu_pend = 1'b0;
      end else begin
        if (vpu_busy > 0) vpu_busy--;
        if (vpu_pend) begin
          vpu_busy = busy_len;
          vpu_pend = 1'b0;
        end
        if (bus.start_VPU && vpu_respond) vpu_pend = 1'b1;
      end
      bus.VPU_rdy = !vpu_hold && (vpu_busy == 0);
    end
  end

  // Reference model: pending commands in a queue, one command in flight whose
  // age counts cycles since its start strobe.
  cmd_t mq[$];
  cmd_t mf = '0;
  bit   m_busy = 1'b0, m_acked = 1'b0, m_err = 1'b0, m_issue, m_push;
  int   m_age = 0;
  cmd_t m_in;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      mf = '0; m_busy = 1'b0; m_acked = 1'b0; m_age = 0; m_err = 1'b0;
    end else begin
      m_in    = bus_cmd();
      m_issue = !m_busy && (mq.size() > 0) && bus.VPU_rdy && !bus.flush;
      m_push  = bus.cmd_valid && (mq.size() < DEPTH) && !bus.flush;
      if (m_busy) begin
        if (m_age == 0) m_age = 1;
        else if (!m_acked) begin
          if (!bus.VPU_rdy) m_acked = 1'b1;
          else if (m_age == ACK_TIMEOUT) begin
            m_busy = 1'b0;
            m_err  = 1'b1;
          end else m_age++;
        end else if (bus.VPU_rdy) m_busy = 1'b0;
      end
      if (bus.flush) mq.delete();
      if (m_issue) begin
        mf = mq.pop_front();
        m_busy = 1'b1; m_acked = 1'b0; m_age = 0;
      end
      if (m_push) mq.push_back(m_in);
    end
  end

  // Per-cycle comparison on the falling edge; also logs every start.
  int log_v1[$];
  int log_cyc[$];
  initial forever begin
    @(negedge clk);
    check_int("start_VPU", int'(bus.start_VPU), int'(m_busy && m_age == 0));
    check_int("q_count", int'(bus.q_count), mq.size());
    check_int("cmd_rdy", int'(bus.cmd_rdy), int'(mq.size() != DEPTH));
    check_int("sched_idle", int'(bus.sched_idle), int'(mq.size() == 0 && !m_busy && bus.VPU_rdy));
    check_int("timeout_err", int'(bus.timeout_err), int'(m_err));
    check_cmd("fields", dut_fields(), mf);
    if (bus.start_VPU) begin
      log_v1.push_back(int'(bus.V1_VPU));
      log_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  cmd_t c;
  initial begin
    rst_n = 1'b1;
    drive('0, 1'b0);
    bus.flush = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_int("post_reset_q_count", int'(bus.q_count), 0);
    check_int("post_reset_cmd_rdy", int'(bus.cmd_rdy), 1);
    check_int("post_reset_start", int'(bus.start_VPU), 0);
    check_int("post_reset_idle", int'(bus.sched_idle), 1);

    // Single command: two edges of latency, then held behind a busy VPU.
    busy_len = 10;
    log_v1.delete(); log_cyc.delete();
    c = mk(100); c.op = 4'h3; c.obj_num = 5'h11; c.v0 = 16'hBEEF;
    enq(c);
    check_int("single_no_start_yet", int'(bus.start_VPU), 0);
    tick();
    check_int("single_start", int'(bus.start_VPU), 1);
    check_int("single_op", int'(bus.op_VPU), 3);
    check_int("single_obj_num", int'(bus.obj_num_VPU), 17);
    check_int("single_V0", int'(bus.V0_VPU), 48879);
    check_int("single_q_popped", int'(bus.q_count), 0);
    tick();
    check_int("single_start_one_cycle", int'(bus.start_VPU), 0);
    enq(mk(101));
    wait_idle(100);
    check_int("single_start_count", log_cyc.size(), 2);
    if (log_cyc.size() == 2) check_int("busy_start_spacing", log_cyc[1] - log_cyc[0], 13);

    // Full queue, dropped 5th, then wrap-around with 10 starts in order.
    busy_len = 1;
    log_v1.delete(); log_cyc.delete();
    vpu_hold = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) enq(mk(s));
    check_int("full_q_count", int'(bus.q_count), 4);
    check_int("full_cmd_rdy", int'(bus.cmd_rdy), 0);
    enq(mk(200));
    check_int("full_drop_q_count", int'(bus.q_count), 4);
    vpu_hold = 1'b0;
    for (int s = 4; s < 10; s++) enq_hold(mk(s), 50);
    wait_idle(200);
    check_int("wrap_start_count", log_v1.size(), 10);
    for (int i = 0; i < 10 && i < log_v1.size(); i++) check_int("wrap_order_V1", log_v1[i], i);
    if (log_cyc.size() >= 2) check_int("b2b_spacing", log_cyc[1] - log_cyc[0], 4);

    // Ack timeout: VPU never drops ready.
    check_int("err_clear_before", int'(bus.timeout_err), 0);
    vpu_respond = 1'b0;
    log_v1.delete(); log_cyc.delete();
    enq(mk(20));
    enq(mk(21));
    wait_idle(100);
    check_int("timeout_err_set", int'(bus.timeout_err), 1);
    check_int("timeout_start_count", log_v1.size(), 2);
    if (log_v1.size() == 2) begin
      check_int("timeout_first_V1", log_v1[0], 20);
      check_int("timeout_next_V1", log_v1[1], 21);
      check_int("timeout_spacing", log_cyc[1] - log_cyc[0], 6);
    end
    vpu_respond = 1'b1;

    // Flush with 3 queued and 1 in flight, together with an enqueue.
    busy_len = 6;
    log_v1.delete(); log_cyc.delete();
    enq(mk(30));
    enq(mk(31));
    enq(mk(32));
    enq(mk(33));
    check_int("pre_flush_q_count", int'(bus.q_count), 3);
    bus.flush = 1'b1;
    enq(mk(34));
    bus.flush = 1'b0;
    check_int("flush_q_count", int'(bus.q_count), 0);
    check_int("flush_cmd_rdy", int'(bus.cmd_rdy), 1);
    wait_idle(100);
    repeat (8) tick();
    check_int("flush_idle", int'(bus.sched_idle), 1);
    check_int("flush_start_count", log_v1.size(), 1);
    if (log_v1.size() == 1) check_int("flush_inflight_V1", log_v1[0], 30);

    // Enqueue coinciding with the pop edge: full, then half full.
    busy_len = 1;
    log_v1.delete(); log_cyc.delete();
    vpu_hold = 1'b1;
    tick();
    for (int s = 40; s < 44; s++) enq(mk(s));
    check_int("simul_full_q_count", int'(bus.q_count), 4);
    drive(mk(44), 1'b1);
    vpu_hold = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    check_int("simul_full_start", int'(bus.start_VPU), 1);
    check_int("simul_full_q_after", int'(bus.q_count), 3);
    check_int("simul_full_cmd_rdy", int'(bus.cmd_rdy), 1);
    wait_idle(200);
    log_v1.delete(); log_cyc.delete();
    vpu_hold = 1'b1;
    tick();
    enq(mk(50));
    enq(mk(51));
    check_int("simul_half_q_before", int'(bus.q_count), 2);
    drive(mk(52), 1'b1);
    vpu_hold = 1'b0;
    tick();
    bus.cmd_valid = 1'b0;
    check_int("simul_half_start", int'(bus.start_VPU), 1);
    check_int("simul_half_q_after", int'(bus.q_count), 2);
    wait_idle(200);
    check_int("simul_half_start_count", log_v1.size(), 3);
    for (int i = 0; i < 3 && i < log_v1.size(); i++) check_int("simul_half_order", log_v1[i], 50 + i);

    // Asynchronous reset in WAIT_DONE with 3 commands queued.
    busy_len = 20;
    enq(mk(60));
    enq(mk(61));
    enq(mk(62));
    enq(mk(63));
    repeat (3) tick();
    check_int("pre_reset_q_count", int'(bus.q_count), 3);
    log_v1.delete(); log_cyc.delete();
    rst_n = 1'b0;
    #1;
    check_int("rst_start", int'(bus.start_VPU), 0);
    check_int("rst_q_count", int'(bus.q_count), 0);
    check_int("rst_cmd_rdy", int'(bus.cmd_rdy), 1);
    check_int("rst_timeout_err", int'(bus.timeout_err), 0);
    check_cmd("rst_fields", dut_fields(), '0);
    check_int("rst_idle_follows_rdy", int'(bus.sched_idle), int'(bus.VPU_rdy));
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (10) tick();
    check_int("post_rst_no_start", log_v1.size(), 0);
    check_int("post_rst_idle", int'(bus.sched_idle), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
